// File: rtl/exe_wb_arbiter.sv
// exe_wb_arbiter: shares the writeback port between the ALU pipe and a
// long-latency unit, with a starvation guard and a 1-entry ALU skid.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module exe_wb_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int RD_WIDTH   = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_stall,
    input  logic                  alu_valid,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [RD_WIDTH-1:0]   alu_rd,
    output logic                  alu_hold,
    input  logic                  llu_valid,
    input  logic [DATA_WIDTH-1:0] llu_result,
    input  logic [RD_WIDTH-1:0]   llu_rd,
    output logic                  llu_ack,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [RD_WIDTH-1:0]   wb_rd,
    output logic                  wb_src
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_nxt;
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [RD_WIDTH-1:0]   skid_rd;
    logic                  skid_load;
    logic                  gnt_skid;
    logic                  gnt_llu;
    logic                  gnt_alu;
    logic                  gnt_any;

    assign alu_hold = skid_vld;
    assign llu_ack  = gnt_llu;
    assign gnt_any  = gnt_skid | gnt_llu | gnt_alu;

    // Grant selection and next-state; nothing is granted in stall or reset.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        gnt_skid     = 1'b0;
        gnt_llu      = 1'b0;
        gnt_alu      = 1'b0;
        skid_load    = 1'b0;
        if (!system_stall && !reset) begin
            unique case (state)
                IDLE: begin
                    if (alu_valid) begin
                        gnt_alu = 1'b1;
                        if (llu_valid) begin
                            wait_cnt_nxt = 4'd1;
                            state_nxt    = WAIT;
                        end
                    end else if (llu_valid) begin
                        gnt_llu = 1'b1;
                    end
                end
                WAIT: begin
                    if (!llu_valid) begin
                        gnt_alu      = alu_valid;
                        wait_cnt_nxt = 4'd0;
                        state_nxt    = IDLE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        gnt_llu      = 1'b1;
                        skid_load    = alu_valid;
                        wait_cnt_nxt = 4'd0;
                        state_nxt    = alu_valid ? DRAIN : IDLE;
                    end else if (alu_valid) begin
                        gnt_alu      = 1'b1;
                        wait_cnt_nxt = (wait_cnt >= WAIT_LIMIT)
                                     ? WAIT_LIMIT
                                     : wait_cnt + 4'd1;
                    end else begin
                        gnt_llu      = 1'b1;
                        wait_cnt_nxt = 4'd0;
                        state_nxt    = IDLE;
                    end
                end
                DRAIN: begin
                    gnt_skid = 1'b1;
                    if (llu_valid) begin
                        wait_cnt_nxt = 4'd1;
                        state_nxt    = WAIT;
                    end else begin
                        wait_cnt_nxt = 4'd0;
                        state_nxt    = IDLE;
                    end
                end
                default: begin
                    wait_cnt_nxt = 4'd0;
                    state_nxt    = IDLE;
                end
            endcase
        end
    end

    // State, wait counter and skid entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            skid_rd   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (gnt_skid) begin
                skid_vld <= 1'b0;
            end else if (skid_load) begin
                skid_vld  <= 1'b1;
                skid_data <= alu_result;
                skid_rd   <= alu_rd;
            end
        end
    end

    // Writeback register; data and rd only move on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_src   <= 1'b0;
        end else begin
            wb_valid <= gnt_any;
            unique case (1'b1)
                gnt_skid: begin
                    wb_data <= skid_data;
                    wb_rd   <= skid_rd;
                    wb_src  <= 1'b0;
                end
                gnt_llu: begin
                    wb_data <= llu_result;
                    wb_rd   <= llu_rd;
                    wb_src  <= 1'b1;
                end
                gnt_alu: begin
                    wb_data <= alu_result;
                    wb_rd   <= alu_rd;
                    wb_src  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
